// File: rtl/std_fp_sacc_pipe.sv
// rtl/std_fp_sacc_pipe.sv - signed fixed-point accumulator with go/done control
//
// Sums len signed WIDTH-bit terms into an ACC_W = WIDTH+GUARD accumulator and
// returns one WIDTH-bit result. The binary point (INT_WIDTH.FRAC_WIDTH) passes
// through unchanged. No rounding is applied.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   go        start/hold, kept high until done; dropping it in ACC aborts
//   len       term count, sampled on the start cycle
//   in        signed term
//   in_valid  term present this cycle
//   in_ready  block accepts a term this cycle
//   out       signed result, held until the next completed operation
//   done      one-cycle pulse, out valid
//
// Optional feature: define STD_FP_SACC_SAT_EN to saturate the result to the
// WIDTH-bit signed range. Otherwise the result wraps (low WIDTH bits of acc).
module std_fp_sacc_pipe #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int GUARD      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [WIDTH-1:0]     in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 done
);

    localparam int ACC_W = WIDTH + GUARD;

    generate
        if (GUARD < CNT_WIDTH) begin : g_guard_check
            $error("std_fp_sacc_pipe: GUARD must be >= CNT_WIDTH");
        end
        if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_point_check
            $error("std_fp_sacc_pipe: INT_WIDTH+FRAC_WIDTH must equal WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FIN
    } state_t;

    state_t                     state;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [CNT_WIDTH-1:0]       len_q;
    // Cleared after each completion so a go still held high past done cannot
    // start a second operation; any low cycle of go re-arms.
    logic                       armed;
    logic signed [ACC_W-1:0]    term_ext;
    logic [WIDTH-1:0]           clamp_val;

    assign term_ext = {{GUARD{in[WIDTH-1]}}, in};
    assign in_ready = (state == S_ACC);

`ifdef STD_FP_SACC_SAT_EN
    // acc fits in WIDTH bits only when all bits from WIDTH-1 upward agree.
    logic acc_hi_ones;
    logic acc_hi_zeros;

    assign acc_hi_ones  = &acc[ACC_W-1:WIDTH-1];
    assign acc_hi_zeros = ~|acc[ACC_W-1:WIDTH-1];

    always_comb begin
        clamp_val = acc[WIDTH-1:0];
        if (!acc_hi_ones && !acc_hi_zeros) begin
            clamp_val = acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_acc_hi;

    assign unused_acc_hi = ^acc[ACC_W-1:WIDTH];
    assign clamp_val     = acc[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            out   <= '0;
            done  <= 1'b0;
            armed <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go && armed) begin
                        len_q <= len;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (len == '0) ? S_FIN : S_ACC;
                    end
                end
                S_ACC: begin
                    // Abort takes priority over a term arriving this cycle.
                    if (!go) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        acc <= acc + term_ext;
                        cnt <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1) begin
                            state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    out   <= clamp_val;
                    done  <= 1'b1;
                    armed <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (!go) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_std_fp_sacc_pipe.sv
// tb/tb_std_fp_sacc_pipe.sv - self-checking bench for std_fp_sacc_pipe
module tb_std_fp_sacc_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [31:0] in_t = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    std_fp_sacc_pipe #(
        .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .CNT_WIDTH(8), .GUARD(8)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .len(len), .in(in_t),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Operation-level model: collects accepted terms into an integer sum and
    // schedules the completion from the protocol timing.
    int          cyc = 0;
    bit          busy = 1'b0;
    bit          armed_m = 1'b1;
    int          want = 0;
    int          got = 0;
    longint      sum = 0;
    int          fin_cyc = -10;
    int          done_cyc = -10;
    logic [31:0] exp_out = 32'd0;

    function automatic logic [31:0] clamp_m(input longint s);
        longint v;
        v = s;
`ifdef STD_FP_SACC_SAT_EN
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        return v[31:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy = 1'b0;
            armed_m = 1'b1;
            exp_out = 32'd0;
            fin_cyc = -10;
            done_cyc = -10;
        end else begin
            cyc++;
            if (cyc == fin_cyc) begin
                exp_out = clamp_m(sum);
                done_cyc = cyc + 1;
                armed_m = 1'b0;
            end else if (!busy) begin
                if (go && armed_m) begin
                    sum = 0;
                    got = 0;
                    want = int'(len);
                    if (want == 0) fin_cyc = cyc + 1;
                    else busy = 1'b1;
                end
            end else if (!go) begin
                busy = 1'b0;
            end else if (in_valid) begin
                sum += longint'($signed(in_t));
                got++;
                if (got == want) begin
                    busy = 1'b0;
                    fin_cyc = cyc + 1;
                end
            end
            if (!go) armed_m = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("model_done", {31'd0, done}, {31'd0, (cyc + 1 == done_cyc)});
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, busy});
        chk("model_out", out, exp_out);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string nm, input int n, input logic [31:0] t0,
                          input logic [31:0] t1, input logic [31:0] t2,
                          input logic [31:0] t3, input logic [31:0] exp);
        logic [31:0] ts [4];
        ts[0] = t0; ts[1] = t1; ts[2] = t2; ts[3] = t3;
        go = 1'b1;
        len = 8'(n);
        tick(1);
        for (int i = 0; i < n; i++) begin
            in_t = ts[i];
            in_valid = 1'b1;
            tick(1);
        end
        in_valid = 1'b0;
        chk({nm, "_fin_no_done"}, {31'd0, done}, 32'd0);
        tick(1);
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_out"}, out, exp);
        tick(1);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        go = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        chk("reset_out", out, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        tick(1);

        run_op("basic", 3, 32'h00018000, 32'h00024000, 32'hFFFF4000, 32'd0, 32'h00030000);

        // Bubbles, then abort after two terms.
        go = 1'b1;
        len = 8'd3;
        tick(1);
        in_t = 32'h00018000; in_valid = 1'b1; tick(1);
        in_valid = 1'b0; tick(2);
        in_t = 32'h00024000; in_valid = 1'b1; tick(1);
        in_valid = 1'b0; tick(2);
        go = 1'b0;
        tick(1);
        chk("abort_idle", {31'd0, in_ready}, 32'd0);
        chk("abort_out_held", out, 32'h00030000);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            tick(1);
        end

        run_op("rerun", 3, 32'h00018000, 32'h00024000, 32'hFFFF4000, 32'd0, 32'h00030000);

        // Zero length and re-arm.
        go = 1'b1;
        len = 8'd0;
        tick(1);
        chk("zero_fin", {31'd0, done}, 32'd0);
        tick(1);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_out", out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("zero_no_restart", {31'd0, done}, 32'd0);
        end
        go = 1'b0;
        tick(1);
        go = 1'b1;
        tick(2);
        chk("zero_rearm_done", {31'd0, done}, 32'd1);
        go = 1'b0;
        tick(2);

`ifdef STD_FP_SACC_SAT_EN
        run_op("neg_ovf", 2, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h80000000);
        run_op("pos_ovf", 4, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF);
`else
        run_op("neg_ovf", 2, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h00000000);
        run_op("pos_ovf", 4, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'hFFFC0000);
`endif

        // Asynchronous reset in the middle of an accumulation.
        go = 1'b1;
        len = 8'd3;
        tick(1);
        in_t = 32'h00018000; in_valid = 1'b1; tick(1);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", out, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        go = 1'b0;
        tick(1);

        run_op("post_reset", 3, 32'h00018000, 32'h00024000, 32'hFFFF4000, 32'd0, 32'h00030000);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
